// File: rtl/window_line_buffer.sv
// Circular line buffer that presents a sliding WIN-pixel window, oldest pixel in the MSB slice.
// Reads advance the window by one pixel; occupancy is tracked as a fill count and a 4-level state.
module window_line_buffer #(
    parameter int DATA_W   = 8,
    parameter int LINE_LEN = 512,
    parameter int WIN      = 3
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            wr_valid_in,
    input  logic [DATA_W-1:0]               wr_data_in,
    input  logic                            rd_en_in,
    output logic [WIN*DATA_W-1:0]           rd_data_out,
    output logic                            rd_valid_out,
    output logic                            line_done_out,
    output logic [$clog2(LINE_LEN+1)-1:0]   fill_count_out,
    output logic [1:0]                      state_out,
    output logic                            full_out,
    output logic                            ovf_out,
    output logic                            udf_out
);

    localparam int PTR_W = $clog2(LINE_LEN);
    localparam int CNT_W = $clog2(LINE_LEN + 1);
    localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WIN);
    localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(LINE_LEN);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(LINE_LEN - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PRIME = 2'd1,
        ST_READY = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    logic [DATA_W-1:0]     mem_q [LINE_LEN];
    logic [PTR_W-1:0]      wp_q, wp_d;
    logic [PTR_W-1:0]      rp_q, rp_d;
    logic [CNT_W-1:0]      fill_q, fill_d;
    logic [WIN*DATA_W-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  line_done_q, line_done_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full_q, full_d;
    state_e                state_q, state_d;
    logic                  rd_acc;
    logic                  wr_acc;

    // (p + off) mod LINE_LEN; off is always below LINE_LEN so one subtraction suffices
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int off);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(off);
        if (s >= (PTR_W+1)'(LINE_LEN)) begin
            s = s - (PTR_W+1)'(LINE_LEN);
        end
        return s[PTR_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_acc      = rd_en_in && (fill_q >= WIN_C);
        wr_acc      = wr_valid_in && ((fill_q < LEN_C) || rd_acc);
        wp_d        = wr_acc ? ptr_inc(wp_q) : wp_q;
        rp_d        = rd_acc ? ptr_inc(rp_q) : rp_q;
        rd_valid_d  = rd_acc;
        line_done_d = rd_acc && (rp_q == LAST_C);
        ovf_d       = ovf_q || (wr_valid_in && !wr_acc);
        udf_d       = udf_q || (rd_en_in && !rd_acc);
        fill_d      = fill_q;
        if (wr_acc && !rd_acc) begin
            fill_d = fill_q + 1'b1;
        end else if (!wr_acc && rd_acc) begin
            fill_d = fill_q - 1'b1;
        end
    end

    // Window is taken from the pre-write memory image, so a same-cycle write at rp is not seen
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            for (int i = 0; i < WIN; i++) begin
                rd_data_d[(WIN-1-i)*DATA_W +: DATA_W] = mem_q[wrap_add(rp_q, i)];
            end
        end
    end

    always_comb begin
        full_d = (fill_d == LEN_C);
        if (fill_d == '0) begin
            state_d = ST_EMPTY;
        end else if (fill_d < WIN_C) begin
            state_d = ST_PRIME;
        end else if (fill_d == LEN_C) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_READY;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_EMPTY;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        state_out = state_q;
        full_out  = full_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            fill_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            line_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            fill_q      <= fill_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            line_done_q <= line_done_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // Pixel storage is never cleared; reset only discards it by zeroing the pointers and fill
    always_ff @(posedge Clk) begin
        if (!Rst && wr_acc) begin
            mem_q[wp_q] <= wr_data_in;
        end
    end

    assign rd_data_out    = rd_data_q;
    assign rd_valid_out   = rd_valid_q;
    assign line_done_out  = line_done_q;
    assign fill_count_out = fill_q;
    assign ovf_out        = ovf_q;
    assign udf_out        = udf_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer: an 8-deep/3-wide instance checked against a pixel-queue model,
// plus a default-parameter instance given a short directed check.
module tb_window_line_buffer;

    localparam int LEN = 8;
    localparam int W   = 3;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        wr_valid_in = 1'b0;
    logic [7:0]  wr_data_in = '0;
    logic        rd_en_in = 1'b0;
    logic [23:0] rd_data_out;
    logic        rd_valid_out, line_done_out, full_out, ovf_out, udf_out;
    logic [3:0]  fill_count_out;
    logic [1:0]  state_out;

    logic        d_wr = 1'b0;
    logic [7:0]  d_wd = '0;
    logic        d_rd = 1'b0;
    logic [23:0] d_data;
    logic        d_valid, d_ld, d_full, d_ovf, d_udf;
    logic [9:0]  d_fill;
    logic [1:0]  d_state;

    int errors = 0;
    int checks = 0;

    // model: the stored pixels in arrival order, plus the count of accepted reads
    logic [7:0]  q[$];
    int          rcount;
    logic [23:0] exp_data;
    logic        exp_valid, exp_ld, exp_ovf, exp_udf;

    window_line_buffer #(.DATA_W(8), .LINE_LEN(LEN), .WIN(W)) dut (
        .Clk(Clk), .Rst(Rst), .wr_valid_in(wr_valid_in), .wr_data_in(wr_data_in),
        .rd_en_in(rd_en_in), .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out),
        .line_done_out(line_done_out), .fill_count_out(fill_count_out), .state_out(state_out),
        .full_out(full_out), .ovf_out(ovf_out), .udf_out(udf_out)
    );

    window_line_buffer dut_d (
        .Clk(Clk), .Rst(Rst), .wr_valid_in(d_wr), .wr_data_in(d_wd),
        .rd_en_in(d_rd), .rd_data_out(d_data), .rd_valid_out(d_valid),
        .line_done_out(d_ld), .fill_count_out(d_fill), .state_out(d_state),
        .full_out(d_full), .ovf_out(d_ovf), .udf_out(d_udf)
    );

    always #5 Clk = ~Clk;

    function automatic logic [1:0] exp_state(input int n);
        if (n == 0) return 2'd0;
        if (n < W) return 2'd1;
        if (n == LEN) return 2'd3;
        return 2'd2;
    endfunction

    task automatic do_reset(input logic wr, input logic rd);
        Rst = 1'b1; wr_valid_in = wr; wr_data_in = 8'hEE; rd_en_in = rd;
        @(posedge Clk); #1;
        Rst = 1'b0; wr_valid_in = 1'b0; rd_en_in = 1'b0;
        q.delete(); rcount = 0; exp_data = '0;
        exp_valid = 1'b0; exp_ld = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [7:0] wd, input logic rd);
        int  n;
        logic ra, wa;
        n  = q.size();
        ra = rd && (n >= W);
        wa = wr && ((n < LEN) || ra);
        exp_valid = ra;
        exp_ld    = ra && (rcount == LEN - 1);
        if (ra) begin
            exp_data = {q[0], q[1], q[2]};
            void'(q.pop_front());
            rcount = (rcount + 1) % LEN;
        end
        if (wa) q.push_back(wd);
        if (wr && !wa) exp_ovf = 1'b1;
        if (rd && !ra) exp_udf = 1'b1;
        wr_valid_in = wr; wr_data_in = wd; rd_en_in = rd;
        @(posedge Clk); #1;
        wr_valid_in = 1'b0; rd_en_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        checks++; if (rd_data_out !== 24'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", rd_data_out); end
        checks++; if (rd_valid_out !== 1'b0 || line_done_out !== 1'b0) begin errors++; $display("FAIL reset_pulses got valid=%b ld=%b exp=0,0", rd_valid_out, line_done_out); end
        checks++; if (fill_count_out !== 4'd0 || state_out !== 2'd0 || full_out !== 1'b0) begin errors++; $display("FAIL reset_occ got fill=%0d st=%0d full=%b exp=0,0,0", fill_count_out, state_out, full_out); end
        checks++; if (ovf_out !== 1'b0 || udf_out !== 1'b0) begin errors++; $display("FAIL reset_sticky got ovf=%b udf=%b exp=0,0", ovf_out, udf_out); end
        checks++; if (d_fill !== 10'd0 || d_state !== 2'd0 || d_data !== 24'h0) begin errors++; $display("FAIL reset_default got fill=%0d st=%0d data=%h exp=0,0,0", d_fill, d_state, d_data); end
    endtask

    task automatic test_basic_read();
        do_reset(1'b0, 1'b0);
        drive(1'b1, 8'h10, 1'b0); drive(1'b1, 8'h11, 1'b0); drive(1'b1, 8'h12, 1'b0);
        checks++; if (fill_count_out !== 4'd3 || state_out !== 2'd2) begin errors++; $display("FAIL basic_ready got fill=%0d st=%0d exp=3,2", fill_count_out, state_out); end
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (rd_data_out !== 24'h101112 || exp_data !== 24'h101112) begin errors++; $display("FAIL basic_window got=%h exp=101112", rd_data_out); end
        checks++; if (rd_valid_out !== 1'b1 || fill_count_out !== 4'd2 || state_out !== 2'd1) begin errors++; $display("FAIL basic_after got valid=%b fill=%0d st=%0d exp=1,2,1", rd_valid_out, fill_count_out, state_out); end
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (rd_valid_out !== 1'b0 || rd_data_out !== 24'h101112) begin errors++; $display("FAIL basic_hold got valid=%b data=%h exp=0,101112", rd_valid_out, rd_data_out); end
    endtask

    task automatic test_underflow();
        do_reset(1'b0, 1'b0);
        drive(1'b1, 8'h21, 1'b0); drive(1'b1, 8'h22, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (rd_valid_out !== 1'b0 || udf_out !== 1'b1) begin errors++; $display("FAIL udf_flag got valid=%b udf=%b exp=0,1", rd_valid_out, udf_out); end
        checks++; if (fill_count_out !== 4'd2 || state_out !== 2'd1 || rd_data_out !== 24'h0) begin errors++; $display("FAIL udf_state got fill=%0d st=%0d data=%h exp=2,1,0", fill_count_out, state_out, rd_data_out); end
    endtask

    task automatic test_full_overflow();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < LEN; i++) drive(1'b1, 8'(i), 1'b0);
        checks++; if (full_out !== 1'b1 || state_out !== 2'd3 || fill_count_out !== 4'd8) begin errors++; $display("FAIL full_state got full=%b st=%0d fill=%0d exp=1,3,8", full_out, state_out, fill_count_out); end
        drive(1'b1, 8'h99, 1'b0);
        checks++; if (ovf_out !== 1'b1 || fill_count_out !== 4'd8 || ovf_out !== exp_ovf) begin errors++; $display("FAIL ovf_drop got ovf=%b fill=%0d exp=1,8", ovf_out, fill_count_out); end
    endtask

    // runs straight on from the full buffer left by test_full_overflow
    task automatic test_simul_and_wrap();
        drive(1'b1, 8'hAA, 1'b1);
        checks++; if (rd_data_out !== 24'h000102 || rd_valid_out !== 1'b1) begin errors++; $display("FAIL simul_window got=%h valid=%b exp=000102,1", rd_data_out, rd_valid_out); end
        checks++; if (fill_count_out !== 4'd8 || full_out !== 1'b1) begin errors++; $display("FAIL simul_fill got fill=%0d full=%b exp=8,1", fill_count_out, full_out); end
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 8'hB0 + 8'(k), 1'b1);
            checks++; if (rd_data_out !== exp_data || rd_valid_out !== exp_valid) begin errors++; $display("FAIL wrap_window k=%0d got=%h exp=%h", k, rd_data_out, exp_data); end
            checks++; if (line_done_out !== exp_ld) begin errors++; $display("FAIL wrap_line_done k=%0d got=%b exp=%b", k, line_done_out, exp_ld); end
            if (k == 5) begin
                checks++; if (rd_data_out !== 24'h0607AA) begin errors++; $display("FAIL wrap_straddle got=%h exp=0607aa", rd_data_out); end
            end
            if (k == 6) begin
                checks++; if (line_done_out !== 1'b1) begin errors++; $display("FAIL wrap_rp7 got=%b exp=1", line_done_out); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0);
        do_reset(1'b1, 1'b1);
        checks++; if (fill_count_out !== 4'd0 || state_out !== 2'd0 || udf_out !== 1'b0 || ovf_out !== 1'b0) begin errors++; $display("FAIL mid_reset got fill=%0d st=%0d udf=%b ovf=%b exp=0,0,0,0", fill_count_out, state_out, udf_out, ovf_out); end
        drive(1'b1, 8'hC0, 1'b0); drive(1'b1, 8'hC1, 1'b0); drive(1'b1, 8'hC2, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (rd_data_out !== 24'hC0C1C2) begin errors++; $display("FAIL mid_addr0 got=%h exp=c0c1c2", rd_data_out); end
    endtask

    task automatic test_random();
        int wr_pct[4] = '{90, 30, 70, 50};
        int rd_pct[4] = '{30, 90, 70, 50};
        do_reset(1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 100; c++) begin
                drive($urandom_range(99) < wr_pct[p], 8'($urandom_range(255)), $urandom_range(99) < rd_pct[p]);
                checks++; if (rd_data_out !== exp_data || rd_valid_out !== exp_valid) begin errors++; $display("FAIL rand_window p=%0d c=%0d got=%h/%b exp=%h/%b", p, c, rd_data_out, rd_valid_out, exp_data, exp_valid); end
                checks++; if (line_done_out !== exp_ld) begin errors++; $display("FAIL rand_line_done p=%0d c=%0d got=%b exp=%b", p, c, line_done_out, exp_ld); end
                checks++; if (fill_count_out !== 4'(q.size()) || state_out !== exp_state(q.size()) || full_out !== (q.size() == LEN)) begin errors++; $display("FAIL rand_occ p=%0d c=%0d got fill=%0d st=%0d full=%b exp fill=%0d", p, c, fill_count_out, state_out, full_out, q.size()); end
                checks++; if (ovf_out !== exp_ovf || udf_out !== exp_udf) begin errors++; $display("FAIL rand_sticky p=%0d c=%0d got ovf=%b udf=%b exp=%b,%b", p, c, ovf_out, udf_out, exp_ovf, exp_udf); end
            end
        end
    endtask

    task automatic test_default();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d_wr = 1'b1; d_wd = 8'h31 + 8'(i);
            @(posedge Clk); #1;
        end
        d_wr = 1'b0; d_rd = 1'b1;
        @(posedge Clk); #1;
        d_rd = 1'b0;
        checks++; if (d_data !== 24'h313233 || d_valid !== 1'b1) begin errors++; $display("FAIL default_window got=%h valid=%b exp=313233,1", d_data, d_valid); end
        checks++; if (d_fill !== 10'd2 || d_state !== 2'd1 || d_udf !== 1'b0) begin errors++; $display("FAIL default_occ got fill=%0d st=%0d udf=%b exp=2,1,0", d_fill, d_state, d_udf); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_underflow();
        test_full_overflow();
        test_simul_and_wrap();
        test_reset_mid();
        test_random();
        test_default();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
